// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer driving a single one-bit ALU slice
//
// aluslice: one-bit ALU cell.
//   a, b         operand bits
//   cin          carry in
//   invta/invtb  invert operand a/b before use
//   sel          000/001/011 sum, 010 xor, 100 and, 101 nand, 110 nor, 111 or
//   result       selected result bit
//   cout         carry out of the (inverted) operand sum
//
// alu_serial_seq: accepts op/a/b over in_valid/in_ready, runs WIDTH cycles
// through the slice LSB-first, and presents result/carryout/overflow/zero
// over out_valid/out_ready.
//   clk, reset            clock, asynchronous active-high reset
//   in_valid, in_ready    operand handshake (in_ready high only in IDLE)
//   op, a, b              opcode and operands
//   out_valid, out_ready  result handshake
//   result, carryout, overflow, zero   registered result and flags

module aluslice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       invta,
  input  logic       invtb,
  input  logic [2:0] sel,
  output logic       result,
  output logic       cout
);
  logic ai, bi, sum;

  assign ai   = a ^ invta;
  assign bi   = b ^ invtb;
  assign sum  = ai ^ bi ^ cin;
  assign cout = (ai & bi) | (ai & cin) | (bi & cin);

  always_comb begin
    result = 1'b0;
    case (sel)
      3'b000, 3'b001, 3'b011: result = sum;
      3'b010:                 result = ai ^ bi;
      3'b100:                 result = ai & bi;
      3'b101:                 result = ~(ai & bi);
      3'b110:                 result = ~(ai | bi);
      default:                result = ai | bi;
    endcase
  end
endmodule

module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;   // bits captured so far; the last bit comes straight from the slice
  logic [CW-1:0]    cnt;
  logic             carry_q;

  // Slice control decoded from the registered opcode, constant during RUN.
  logic [2:0] sel;
  logic       invta, invtb, cin_init;

  // Same decode applied to the incoming opcode for the initial carry.
  function automatic logic init_carry(input logic [2:0] o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

  always_comb begin
    sel      = 3'b000;
    invta    = 1'b0;
    invtb    = 1'b0;
    cin_init = init_carry(op_q);
    case (op_q)
      OP_ADD:  sel = 3'b000;
      OP_SUB:  begin sel = 3'b001; invtb = 1'b1; end
      OP_XOR:  sel = 3'b010;
      OP_SLT:  begin sel = 3'b011; invtb = 1'b1; end
      // AND and OR reuse NOR/NAND on inverted operands (De Morgan).
      OP_AND:  begin sel = 3'b110; invta = 1'b1; invtb = 1'b1; end
      OP_NAND: sel = 3'b101;
      OP_NOR:  sel = 3'b110;
      default: begin sel = 3'b101; invta = 1'b1; invtb = 1'b1; end
    endcase
  end

  logic slice_res, slice_cout;

  aluslice u_slice (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry_q),
    .invta  (invta),
    .invtb  (invtb),
    .sel    (sel),
    .result (slice_res),
    .cout   (slice_cout)
  );

  // Final values, meaningful only in the cycle that captures bit WIDTH-1.
  logic [WIDTH-1:0] res_full, fin_res;
  logic             is_arith, is_slt, ovf_bit;

  assign res_full = {slice_res, res_sh};
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_slt   = (op_q == OP_SLT);
  // carry_q holds the carry into the MSB during the last bit.
  assign ovf_bit  = carry_q ^ slice_cout;
  assign fin_res  = is_slt ? {{(WIDTH-1){1'b0}}, slice_res ^ ovf_bit} : res_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 3'b000;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            a_sh     <= a;
            b_sh     <= b;
            cnt      <= '0;
            carry_q  <= init_carry(op);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_full[WIDTH-1:1];
          carry_q <= slice_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result    <= fin_res;
            carryout  <= is_arith & slice_cout;
            overflow  <= is_arith & ovf_bit;
            zero      <= (fin_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // cin_init documents the decode table; the accept path uses init_carry(op) directly.
  logic unused_ok;
  assign unused_ok = cin_init;
endmodule
